io_input_cond: RTL and testbench

//  Conditions the raw DE2 switch/button pins before they reach the single-cycle core's i_io_sw/i_io_btn.
//  - Synchronizes the pins into i_clk.
//  - Debounces the buttons, each with its own counter and FSM.
//  - Debounces the switches with a shared sample tick.
//  - Emits one-cycle press/release event pulses for each button.

---
 rtl/io_pkg.sv | 16 +
 rtl/btn_debounce.sv | 91 +++++++++
 rtl/io_input_cond.sv | 72 +++++++
 tb/tb_io_input_cond.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and helpers for the DE2 input-conditioning path.
package io_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  // Width that holds 0..db_cycles without wrapping.
  function automatic int db_cnt_w(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: synchronizer chain, debounce FSM with its own counter,
// debounced level (raw polarity) and one-cycle press/release pulses.
module btn_debounce
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int            CW       = db_cnt_w(DB_CYCLES);
  localparam logic          RL       = ACTIVE_LOW;
  localparam logic          PL       = ~ACTIVE_LOW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   act_reg;
  btn_state_e             state_reg;
  logic [CW-1:0]          cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg  <= {SYNC_STAGES{RL}};
      act_reg   <= 1'b0;
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      o_level   <= RL;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], i_raw};
      // Registered compare keeps the FSM off the synchronizer output and
      // puts the output edge SYNC_STAGES+DB_CYCLES clocks after the input edge.
      act_reg   <= (sync_reg[SYNC_STAGES-1] == PL);
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state_reg)
        RELEASED: begin
          if (act_reg) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!act_reg) begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
            o_level   <= PL;
            o_press   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!act_reg) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (act_reg) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
            o_level   <= RL;
            o_release <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_input_cond.sv
// Conditions raw DE2 switch/button pins for the core's input-peripheral region:
// synchronize, debounce (per-button FSMs, shared-tick switch sampling), event pulses.
module io_input_cond
  import io_pkg::*;
#(
  parameter int N_SW           = 32,
  parameter int N_BTN          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SW-1:0]  i_sw_raw,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_SW-1:0]  o_io_sw,
  output logic [N_BTN-1:0] o_io_btn,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release
);

  localparam int            CW        = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][N_SW-1:0] sw_sync_reg;
  logic [N_SW-1:0]                  sw_s;
  logic [N_SW-1:0]                  sw_prev_reg;
  logic [N_SW-1:0]                  sw_stable;
  logic [CW-1:0]                    tick_cnt_reg;
  logic                             tick;

  assign sw_s      = sw_sync_reg[SYNC_STAGES-1];
  assign tick      = (tick_cnt_reg == TICK_LAST);
  assign sw_stable = ~(sw_s ^ sw_prev_reg);

  // A switch bit only moves when two consecutive tick samples agree.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_sync_reg  <= '0;
      sw_prev_reg  <= '0;
      tick_cnt_reg <= '0;
      o_io_sw      <= '0;
    end else begin
      sw_sync_reg <= {sw_sync_reg[SYNC_STAGES-2:0], i_sw_raw};
      if (tick) begin
        tick_cnt_reg <= '0;
        sw_prev_reg  <= sw_s;
        o_io_sw      <= (o_io_sw & ~sw_stable) | (sw_s & sw_stable);
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES),
        .ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) u_btn_debounce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_raw    (i_btn_raw[gi]),
        .o_level  (o_io_btn[gi]),
        .o_press  (o_btn_press[gi]),
        .o_release(o_btn_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_io_input_cond.sv
// Self-checking bench for io_input_cond: table vectors, corner-case sequences,
// and randomized stimulus against a sample-history reference model.
module tb_io_input_cond;

  localparam int SYNC = 2;
  localparam int DB   = 8;
  localparam int LAT  = SYNC + DB;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_press;
  logic [3:0]  btn_release;

  int n_vec = 0;
  int n_err = 0;

  io_input_cond #(
    .N_SW(32), .N_BTN(4), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sw_raw     (sw_raw),
    .i_btn_raw    (btn_raw),
    .o_io_sw      (io_sw),
    .o_io_btn     (io_btn),
    .o_btn_press  (btn_press),
    .o_btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: raw samples per edge, newest at index 0.
  logic [3:0]  bhist[$];
  logic [31:0] shist[$];
  logic [3:0]  m_btn, m_press, m_rel;
  logic [31:0] m_sw, m_prev;
  int          m_edges;

  function automatic void model_reset();
    bhist.delete();
    shist.delete();
    for (int j = 0; j <= LAT; j++) bhist.push_back(4'hF);
    for (int j = 0; j <= SYNC; j++) shist.push_back(32'h0);
    m_btn = 4'hF; m_press = 4'h0; m_rel = 4'h0;
    m_sw = 32'h0; m_prev = 32'h0; m_edges = 0;
  endfunction

  // A button flips once the DB samples ending SYNC+1 edges ago all sit at the other level.
  function automatic void model_edge(input logic [3:0] b, input logic [31:0] s);
    logic [31:0] smp, keep;
    int n_pr;
    bhist.push_front(b); void'(bhist.pop_back());
    shist.push_front(s); void'(shist.pop_back());
    m_press = 4'h0; m_rel = 4'h0;
    for (int i = 0; i < 4; i++) begin
      n_pr = 0;
      for (int j = SYNC + 1; j <= LAT; j++) if (bhist[j][i] == 1'b0) n_pr++;
      if (m_btn[i] && n_pr == DB) begin
        m_btn[i] = 1'b0; m_press[i] = 1'b1;
      end else if (!m_btn[i] && n_pr == 0) begin
        m_btn[i] = 1'b1; m_rel[i] = 1'b1;
      end
    end
    m_edges++;
    if (m_edges % DB == 0) begin
      smp    = shist[SYNC];
      keep   = ~(smp ^ m_prev);
      m_sw   = (m_sw & ~keep) | (smp & keep);
      m_prev = smp;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("io_btn", 32'(io_btn), 32'(m_btn));
    check("btn_press", 32'(btn_press), 32'(m_press));
    check("btn_release", 32'(btn_release), 32'(m_rel));
    check("io_sw", io_sw, m_sw);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(btn_raw, sw_raw);
    else model_reset();
    #1;
    check_model();
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  task automatic measure(input int bi, input bit want_press, input int span,
                         output int first_s, output int n_pulse);
    first_s = -1;
    n_pulse = 0;
    for (int s = 0; s < span; s++) begin
      step();
      if (want_press ? btn_press[bi] : btn_release[bi]) begin
        n_pulse++;
        if (first_s < 0) first_s = s;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  btn;
    logic [31:0] sw;
    int          cycles;
    logic [3:0]  exp_btn;
    logic [31:0] exp_sw;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int fs, np, ps, rs, cnt, sw_t, idx;

    tbl[0] = '{4'hF, 32'hA5A5_0F0F, 20, 4'hF, 32'hA5A5_0F0F};
    tbl[1] = '{4'hE, 32'hA5A5_0F0F, 12, 4'hE, 32'hA5A5_0F0F};
    tbl[2] = '{4'h6, 32'h0000_FFFF, 20, 4'h6, 32'h0000_FFFF};
    tbl[3] = '{4'hF, 32'h1234_5678, 20, 4'hF, 32'h1234_5678};
    tbl[4] = '{4'h7, 32'hA5A5_0F0F, 20, 4'h7, 32'hA5A5_0F0F};

    // Reset with all pins high
    rst_n = 1'b0; btn_raw = 4'hF; sw_raw = 32'hFFFF_FFFF;
    model_reset();
    repeat (3) step();
    check("rst_io_btn", 32'(io_btn), 32'h0000_000F);
    check("rst_io_sw", io_sw, 32'h0);
    check("rst_pulses", 32'(btn_press | btn_release), 32'h0);
    rst_n = 1'b1;
    sw_t = -1; cnt = 0;
    for (int s = 1; s <= 18 && sw_t < 0; s++) begin
      step();
      cnt += int'(btn_press != 4'h0) + int'(btn_release != 4'h0);
      if (io_sw === 32'hFFFF_FFFF) sw_t = s;
    end
    check("rst_sw_settle", 32'(sw_t > 0), 32'd1);
    check("rst_no_btn_event", 32'(cnt), 32'd0);

    // Clean press / release on btn0
    btn_raw = 4'hE;
    measure(0, 1'b1, 16, fs, np);
    check("press0_latency", 32'(fs), 32'(LAT));
    check("press0_count", 32'(np), 32'd1);
    check("press0_level", 32'(io_btn), 32'h0000_000E);
    btn_raw = 4'hF;
    measure(0, 1'b0, 16, fs, np);
    check("release0_latency", 32'(fs), 32'(LAT));
    check("release0_count", 32'(np), 32'd1);
    check("release0_level", 32'(io_btn), 32'h0000_000F);

    // Bounce on btn1 every 3 clocks, then held pressed
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      btn_raw[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      cnt += int'(btn_press[1]) + int'(btn_release[1]);
    end
    check("bounce3_early", 32'(cnt), 32'd0);
    btn_raw[1] = 1'b0;
    measure(1, 1'b1, 16, fs, np);
    check("bounce3_latency", 32'(fs), 32'(LAT));
    check("bounce3_count", 32'(np), 32'd1);
    btn_raw[1] = 1'b1;
    measure(1, 1'b0, 16, fs, np);
    check("bounce3_release", 32'(np), 32'd1);

    // Toggle every 7 clocks: never long enough
    cnt = 0;
    for (int i = 0; i < 82; i++) begin
      btn_raw[1] = (i < 70 && (i / 7) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      cnt += int'(btn_press[1]) + int'(btn_release[1]) + int'(!io_btn[1]);
    end
    check("bounce7_quiet", 32'(cnt), 32'd0);

    // Table vectors: hold inputs, then compare settled outputs
    for (int v = 0; v < 5; v++) begin
      btn_raw = tbl[v].btn; sw_raw = tbl[v].sw;
      repeat (tbl[v].cycles) step();
      $display("vec %0d btn=%h sw=%h -> io_btn=%h io_sw=%h", v, tbl[v].btn, tbl[v].sw, io_btn, io_sw);
      check("tbl_io_btn", 32'(io_btn), 32'(tbl[v].exp_btn));
      check("tbl_io_sw", io_sw, tbl[v].exp_sw);
    end

    // 5-clock glitch on switch bit 0
    cnt = 0;
    sw_raw[0] = 1'b0;
    for (int i = 0; i < 29; i++) begin
      if (i == 5) sw_raw[0] = 1'b1;
      step();
      cnt += int'(io_sw !== 32'hA5A5_0F0F);
    end
    check("sw_glitch_held", 32'(cnt), 32'd0);

    // btn2 press and btn3 release on the same edge
    btn_raw = 4'hB; ps = -1; rs = -1;
    for (int s = 0; s < 16; s++) begin
      step();
      if (btn_press[2] && ps < 0) ps = s;
      if (btn_release[3] && rs < 0) rs = s;
    end
    check("simul_press2", 32'(ps), 32'(LAT));
    check("simul_release3", 32'(rs), 32'(LAT));

    // Reset in the middle of PRESS_WAIT with btn0 held pressed
    btn_raw = 4'hF;
    repeat (16) step();
    btn_raw = 4'hE;
    repeat (8) step();
    pulse_reset(3);
    check("midrst_level", 32'(io_btn), 32'h0000_000F);
    measure(0, 1'b1, 16, fs, np);
    check("midrst_latency", 32'(fs), 32'(LAT));
    check("midrst_count", 32'(np), 32'd1);

    // Randomized stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, 3));
        btn_raw[idx] = ~btn_raw[idx];
      end
      if ($urandom_range(0, 19) == 0) sw_raw = sw_raw ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) sw_raw = $urandom;
      if ($urandom_range(0, 599) == 0) pulse_reset(2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
